// File: rtl/teclado_pkg.sv
// Shared definitions for the keypad scanner and its driver: state encoding,
// default timing parameters and matrix dimensions.
package teclado_pkg;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2
  } estado_t;

  localparam int unsigned SCAN_DIV_PADRAO = 50000;
  localparam int unsigned DEBOUNCE_PADRAO = 4;

  localparam int unsigned NUM_LINHAS  = 4;
  localparam int unsigned NUM_COLUNAS = 4;

endpackage

// File: rtl/varredor_teclado_if.sv
// Keypad-side lines plus the decoded key report consumed by the keypad driver.
interface varredor_teclado_if;
  import teclado_pkg::*;

  logic [NUM_LINHAS-1:0]  linhas_in;
  logic [NUM_COLUNAS-1:0] colunas_out;
  logic [3:0]             linha;
  logic [3:0]             coluna;
  logic                   valido;
  logic                   pressionado;

  modport master (
    input  linhas_in,
    output colunas_out,
    output linha,
    output coluna,
    output valido,
    output pressionado
  );

  modport slave (
    output linhas_in,
    input  colunas_out,
    input  linha,
    input  coluna,
    input  valido,
    input  pressionado
  );

endinterface

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones
// so idle pulled-up lines read as released.
module sincronizador_2ff #(
  parameter int unsigned LARGURA = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] d_i,
  output logic [LARGURA-1:0] q_o
);

  logic [LARGURA-1:0] meta_q;
  logic [LARGURA-1:0] sinc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sinc_q <= '1;
    end else begin
      meta_q <= d_i;
      sinc_q <= meta_q;
    end
  end

  assign q_o = sinc_q;

endmodule

// File: rtl/varredor_teclado.sv
// 4x4 matrix keypad scanner: strobes columns, debounces a single pressed key
// and reports its row/column once per press with a one-cycle valido strobe.
module varredor_teclado
  import teclado_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_PADRAO,
  parameter int unsigned DEBOUNCE = DEBOUNCE_PADRAO
) (
  input  logic                clk,
  input  logic                rst,
  varredor_teclado_if.master  bus
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  logic [3:0]    ls;
  logic [CW-1:0] cont_q;
  logic          tick;
  logic [1:0]    ci_q;
  estado_t       estado_q;
  logic [1:0]    cand_lin_q;
  logic [1:0]    cand_col_q;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] rel_q;
  logic [1:0]    linha_q;
  logic [1:0]    coluna_q;
  logic          valido_q;
  logic          pressionado_q;
  logic [1:0]    ri;
  logic          unica;

  sincronizador_2ff #(
    .LARGURA (NUM_LINHAS)
  ) u_sinc (
    .clk (clk),
    .rst (rst),
    .d_i (bus.linhas_in),
    .q_o (ls)
  );

  assign tick = (cont_q == CW'(SCAN_DIV - 1));

  // Exactly one row low is a usable press; anything else counts as no key.
  always_comb begin
    ri    = 2'd0;
    unica = 1'b0;
    case (ls)
      4'b1110: begin ri = 2'd0; unica = 1'b1; end
      4'b1101: begin ri = 2'd1; unica = 1'b1; end
      4'b1011: begin ri = 2'd2; unica = 1'b1; end
      4'b0111: begin ri = 2'd3; unica = 1'b1; end
      default: begin ri = 2'd0; unica = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cont_q        <= '0;
      ci_q          <= 2'd0;
      estado_q      <= ST_SCAN;
      cand_lin_q    <= 2'd0;
      cand_col_q    <= 2'd0;
      cnt_q         <= '0;
      rel_q         <= '0;
      linha_q       <= 2'd0;
      coluna_q      <= 2'd0;
      valido_q      <= 1'b0;
      pressionado_q <= 1'b0;
    end else begin
      valido_q <= 1'b0;
      cont_q   <= tick ? '0 : cont_q + 1'b1;
      if (tick) begin
        case (estado_q)
          ST_SCAN: begin
            if (unica) begin
              cand_lin_q <= ri;
              cand_col_q <= ci_q;
              cnt_q      <= DW'(1);
              if (DEBOUNCE == 1) begin
                linha_q       <= ri;
                coluna_q      <= ci_q;
                valido_q      <= 1'b1;
                pressionado_q <= 1'b1;
                rel_q         <= '0;
                estado_q      <= ST_HELD;
              end else begin
                estado_q <= ST_CONFIRM;
              end
            end else begin
              ci_q <= ci_q + 2'd1;
            end
          end
          ST_CONFIRM: begin
            if (unica && (ri == cand_lin_q)) begin
              cnt_q <= cnt_q + 1'b1;
              if ((cnt_q + 1'b1) == DW'(DEBOUNCE)) begin
                linha_q       <= cand_lin_q;
                coluna_q      <= cand_col_q;
                valido_q      <= 1'b1;
                pressionado_q <= 1'b1;
                rel_q         <= '0;
                estado_q      <= ST_HELD;
              end
            end else begin
              estado_q <= ST_SCAN;
              ci_q     <= ci_q + 2'd1;
            end
          end
          ST_HELD: begin
            if (ls == 4'b1111) begin
              if ((rel_q + 1'b1) == DW'(DEBOUNCE)) begin
                rel_q         <= '0;
                pressionado_q <= 1'b0;
                estado_q      <= ST_SCAN;
                ci_q          <= ci_q + 2'd1;
              end else begin
                rel_q <= rel_q + 1'b1;
              end
            end else begin
              rel_q <= '0;
            end
          end
          default: estado_q <= ST_SCAN;
        endcase
      end
    end
  end

  assign bus.colunas_out = ~(4'b0001 << ci_q);
  assign bus.linha       = {2'b00, linha_q};
  assign bus.coluna      = {2'b00, coluna_q};
  assign bus.valido      = valido_q;
  assign bus.pressionado = pressionado_q;

endmodule

// File: tb/tb_varredor_teclado.sv
// Bench for varredor_teclado: keypad matrix model, directed scenarios and
// randomized presses checked cycle by cycle against a behavioural model.
module tb_varredor_teclado;

  localparam int SD  = 4;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] teclas = 16'h0;  // bit r*4+c set = key (r,c) held down

  int total = 0;
  int bad   = 0;

  varredor_teclado_if bus ();

  varredor_teclado #(
    .SCAN_DIV (SD),
    .DEBOUNCE (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low only while its column is strobed.
  always_comb begin
    bus.linhas_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (teclas[r*4+c] && !bus.colunas_out[c]) bus.linhas_in[r] = 1'b0;
  end

  // Reference model state
  int m_cont = 0, m_ci = 0, m_fase = 0, m_cr = 0, m_cc = 0, m_deb = 0, m_rel = 0;
  int m_lin = 0, m_col = 0, m_val = 0;
  int m_s1 = 15, m_s2 = 15;
  int pulsos = 0, ult_lin = 0, ult_col = 0;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic aceita();
    m_lin  = m_cr;
    m_col  = m_cc;
    m_val  = 1;
    m_fase = 2;
    m_rel  = 0;
  endtask

  // One clock: advance the model from pre-edge values, then compare all outputs.
  task automatic passo();
    int raw, ls, zeros, r;
    raw = 15;
    for (int rr = 0; rr < 4; rr++)
      if (teclas[rr*4+m_ci]) raw = raw & ~(1 << rr);
    @(posedge clk);
    if (rst) begin
      m_cont = 0; m_ci = 0; m_fase = 0; m_cr = 0; m_cc = 0; m_deb = 0; m_rel = 0;
      m_lin = 0; m_col = 0; m_val = 0; m_s1 = 15; m_s2 = 15;
    end else begin
      m_val = 0;
      if (m_cont == SD - 1) begin
        ls = m_s2;
        zeros = 0;
        r = 0;
        for (int b = 0; b < 4; b++)
          if (((ls >> b) & 1) == 0) begin
            zeros++;
            r = b;
          end
        if (m_fase == 0) begin
          if (zeros == 1) begin
            m_cr = r; m_cc = m_ci; m_deb = 1;
            if (DEB == 1) aceita(); else m_fase = 1;
          end else m_ci = (m_ci + 1) % 4;
        end else if (m_fase == 1) begin
          if (zeros == 1 && r == m_cr) begin
            m_deb++;
            if (m_deb == DEB) aceita();
          end else begin
            m_fase = 0;
            m_ci = (m_ci + 1) % 4;
          end
        end else begin
          if (ls == 15) begin
            m_rel++;
            if (m_rel == DEB) begin
              m_rel = 0; m_fase = 0; m_ci = (m_ci + 1) % 4;
            end
          end else m_rel = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      m_cont = (m_cont + 1) % SD;
    end
    #1;
    verifica("colunas_out", bus.colunas_out, (~(1 << m_ci)) & 15);
    verifica("linha", bus.linha, m_lin);
    verifica("coluna", bus.coluna, m_col);
    verifica("valido", bus.valido, m_val);
    verifica("pressionado", bus.pressionado, (m_fase == 2) ? 1 : 0);
    if (bus.valido === 1'b1) begin
      pulsos++;
      ult_lin = bus.linha;
      ult_col = bus.coluna;
    end
  endtask

  task automatic roda(input int n);
    for (int i = 0; i < n; i++) passo();
  endtask

  initial begin
    int vista, antes, dur, per, k, r1, r2, c1;
    logic [15:0] alvo;

    // Reset, then idle scanning
    rst = 1'b1;
    roda(2);
    verifica("reset_colunas", bus.colunas_out, 4'b1110);
    verifica("reset_linha", bus.linha, 0);
    verifica("reset_press", bus.pressionado, 0);
    rst = 1'b0;
    pulsos = 0;
    for (int i = 0; i < 40; i++) begin
      passo();
      verifica("idle_colunas", bus.colunas_out, (~(1 << (((i + 1) / SD) % 4))) & 15);
    end
    verifica("idle_pulsos", pulsos, 0);

    // Steady press (2,1)
    pulsos = 0;
    teclas = 16'h0;
    teclas[2*4+1] = 1'b1;
    roda(60);
    verifica("p21_pulsos", pulsos, 1);
    verifica("p21_linha", ult_lin, 2);
    verifica("p21_coluna", ult_col, 1);
    verifica("p21_press", bus.pressionado, 1);
    verifica("p21_colunas", bus.colunas_out, 4'b1101);

    // Release: scanning resumes at the next column
    pulsos = 0;
    teclas = 16'h0;
    vista = 0;
    for (int i = 0; i < 40; i++) begin
      antes = bus.pressionado;
      passo();
      if (antes == 1 && bus.pressionado === 1'b0) begin
        vista = 1;
        verifica("solta_retoma", bus.colunas_out, 4'b1011);
      end
    end
    verifica("solta_vista", vista, 1);
    verifica("solta_pulsos", pulsos, 0);

    // Bouncing (3,3): alternate every tick for 5 ticks, then stable
    pulsos = 0;
    for (int t = 0; t < 5; t++) begin
      teclas = 16'h0;
      teclas[3*4+3] = (t % 2 == 0);
      roda(SD);
    end
    verifica("bounce_pulsos", pulsos, 0);
    teclas = 16'h0;
    teclas[3*4+3] = 1'b1;
    roda(60);
    verifica("p33_pulsos", pulsos, 1);
    verifica("p33_linha", ult_lin, 3);
    verifica("p33_coluna", ult_col, 3);
    teclas = 16'h0;
    roda(30);

    // Ghosting: (0,2) and (1,2) together, then release (1,2)
    pulsos = 0;
    teclas[0*4+2] = 1'b1;
    teclas[1*4+2] = 1'b1;
    roda(60);
    verifica("ghost_pulsos", pulsos, 0);
    teclas[1*4+2] = 1'b0;
    roda(60);
    verifica("p02_pulsos", pulsos, 1);
    verifica("p02_linha", ult_lin, 0);
    verifica("p02_coluna", ult_col, 2);
    teclas = 16'h0;
    roda(30);

    // Reset while held with (2,1) down
    teclas[2*4+1] = 1'b1;
    roda(60);
    verifica("pre_rst_press", bus.pressionado, 1);
    rst = 1'b1;
    passo();
    rst = 1'b0;
    verifica("rst_colunas", bus.colunas_out, 4'b1110);
    verifica("rst_linha", bus.linha, 0);
    verifica("rst_coluna", bus.coluna, 0);
    verifica("rst_press", bus.pressionado, 0);
    pulsos = 0;
    roda(60);
    verifica("rst_pulsos", pulsos, 1);
    verifica("rst_linha2", ult_lin, 2);
    verifica("rst_coluna2", ult_col, 1);
    teclas = 16'h0;
    roda(30);

    // Randomized presses, ghosting and bounce
    for (int i = 0; i < 30; i++) begin
      k  = $urandom_range(0, 9);
      r1 = $urandom_range(0, 3);
      r2 = (r1 + $urandom_range(1, 3)) % 4;
      c1 = $urandom_range(0, 3);
      alvo = 16'h0;
      if (k <= 6) alvo[r1*4+c1] = 1'b1;
      else if (k == 7) begin
        alvo[r1*4+c1] = 1'b1;
        alvo[r2*4+c1] = 1'b1;
      end else if (k == 8) begin
        alvo[r1*4+c1] = 1'b1;
        alvo[r2*4+((c1 + 1) % 4)] = 1'b1;
      end
      dur = $urandom_range(4, 70);
      per = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      for (int j = 0; j < dur; j++) begin
        if (per != 0 && j < 20) teclas = ((j / per) % 2 == 0) ? alvo : 16'h0;
        else teclas = alvo;
        passo();
      end
      if ($urandom_range(0, 2) == 0) begin
        teclas = 16'h0;
        roda($urandom_range(1, 30));
      end
    end
    teclas = 16'h0;
    roda(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
